// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative multiply/divide unit that owns the architectural HI/LO pair.
// A start pulse accepted in IDLE latches the operands. The unit then spends
// WIDTH cycles in CALC doing one shift-add or shift-subtract step per cycle
// on unsigned magnitudes. A single FIXUP cycle applies the sign correction,
// writes HI/LO and pulses done. MTHI/MTLO writes are taken only in IDLE.
//
// Ports
//   clock    : rising-edge clock
//   reset    : asynchronous, active-low reset
//   start    : issue pulse, sampled only in IDLE
//   op       : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data  : operand A (multiplicand/dividend, MTHI/MTLO source)
//   rt_data  : operand B (multiplier/divisor)
//   mthi     : write rs_data into HI (IDLE only)
//   mtlo     : write rs_data into LO (IDLE only)
//   busy     : operation in progress (CALC or FIXUP)
//   done     : one-cycle pulse when HI/LO hold a fresh result
//   hi, lo   : HI/LO architectural registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q;
  logic [1:0]           op_q;
  logic                 signA_q;
  logic                 signB_q;
  logic [WIDTH-1:0]     bMag_q;
  logic [WIDTH-1:0]     rsLatch_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 done_q;

  logic                 aNegIn;
  logic                 bNegIn;
  logic [WIDTH-1:0]     aMagIn;
  logic [WIDTH-1:0]     bMagIn;

  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH-1:0]   mulNext;
  logic [WIDTH:0]       divShift;
  logic [WIDTH+1:0]     divDiff;
  logic [2*WIDTH-1:0]   divNext;

  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     quoFix;
  logic [WIDTH-1:0]     remFix;
  logic [WIDTH-1:0]     resHi;
  logic [WIDTH-1:0]     resLo;

  // Operand conditioning at issue: signs are only meaningful for the signed
  // ops (op[0]==0). Negating 0x80000000 yields 0x80000000, which is the
  // correct unsigned magnitude, so no overflow special case is needed.
  always_comb begin
    aNegIn = ~op[0] & rs_data[WIDTH-1];
    bNegIn = ~op[0] & rt_data[WIDTH-1];
    aMagIn = aNegIn ? -rs_data : rs_data;
    bMagIn = bNegIn ? -rt_data : rt_data;
  end

  // One iteration step for each algorithm. Both share acc_q:
  //   multiply: acc = {partial high, remaining multiplier bits}; add bMag into
  //             the top half when the low bit is set, then shift right.
  //   divide:   acc = {remainder, dividend/quotient}; shift left one bit and
  //             subtract bMag when it fits (restoring division).
  // The extra top bit of divDiff is the borrow; with bMag=0 the subtract
  // always succeeds, which produces an all-ones quotient naturally.
  always_comb begin
    if (acc_q[0]) begin
      mulSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, bMag_q};
    end else begin
      mulSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    mulNext  = {mulSum, acc_q[WIDTH-1:1]};

    divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divDiff  = {1'b0, divShift} - {2'b00, bMag_q};
    if (!divDiff[WIDTH+1]) begin
      divNext = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      divNext = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction applied in FIXUP. Signs were forced to zero for the
  // unsigned ops at issue, so the same expressions serve MULTU/DIVU.
  // Divide by zero bypasses the correction: LO is all ones and HI returns
  // the dividend exactly as it was latched.
  always_comb begin
    product = (signA_q ^ signB_q) ? -acc_q : acc_q;
    quoFix  = (signA_q ^ signB_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remFix  = signA_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (!op_q[1]) begin
      resHi = product[2*WIDTH-1:WIDTH];
      resLo = product[WIDTH-1:0];
    end else if (bMag_q == '0) begin
      resHi = rsLatch_q;
      resLo = '1;
    end else begin
      resHi = remFix;
      resLo = quoFix;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: CALC runs exactly WIDTH steps, FIXUP is one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (count_q == CW'(WIDTH - 1)) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: busy is decoded from state; done, hi and lo are registered.
  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // Datapath registers. start wins over mthi/mtlo in IDLE, and everything
  // except the CALC/FIXUP sequence is ignored while busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      op_q      <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      bMag_q    <= '0;
      rsLatch_q <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            signA_q   <= aNegIn;
            signB_q   <= bNegIn;
            bMag_q    <= bMagIn;
            rsLatch_q <= rs_data;
            acc_q     <= {{WIDTH{1'b0}}, aMagIn};
            count_q   <= '0;
          end else begin
            if (mthi) hi_q <= rs_data;
            if (mtlo) lo_q <= rs_data;
          end
        end
        CALC: begin
          acc_q   <= op_q[1] ? divNext : mulNext;
          count_q <= count_q + CW'(1);
        end
        FIXUP: begin
          hi_q   <= resHi;
          lo_q   <= resLo;
          done_q <= 1'b1;
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Self-checking bench for muldiv_unit. Each issued operation pushes its
// expected HI/LO (from a behavioural 64-bit model) onto a queue; a monitor
// pops and compares whenever done pulses.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  rsData;
  logic [W-1:0]  rtData;
  logic          mthi;
  logic          mtlo;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         expQ[$];
  exp_t         monE;
  logic [W-1:0] mHi;
  logic [W-1:0] mLo;
  int           bc;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rsData),
    .rt_data (rtData),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model returning {hi, lo}, built on native 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = '0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          p  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput({monE.tag, "_hi"}, {32'd0, hi}, {32'd0, monE.hi});
        checkOutput({monE.tag, "_lo"}, {32'd0, lo}, {32'd0, monE.lo});
        mHi = monE.hi;
        mLo = monE.lo;
      end
    end
  end

  // Issue one operation at the current negedge and follow it to its done
  // pulse. Returns at the negedge where done is high. Optionally asserts
  // mtlo with start, or disturbs the inputs five busy cycles in.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input string tag, input bit disturb, input bit withMtlo,
                               output int busyCycles);
    logic [63:0] r;
    bit          seen;
    bit          holdBad;
    op     = o;
    rsData = a;
    rtData = b;
    start  = 1'b1;
    mtlo   = withMtlo;
    r = model(o, a, b);
    expQ.push_back('{tag, r[63:32], r[31:0]});
    @(posedge clock);
    #1;
    start  = 1'b0;
    mtlo   = 1'b0;
    rsData = $urandom;
    rtData = $urandom;
    busyCycles = 0;
    seen       = 1'b0;
    holdBad    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) begin
        busyCycles++;
        if (hi !== mHi || lo !== mLo) holdBad = 1'b1;
      end
      if (disturb && busyCycles == 5) begin
        rsData = 32'hDEAD_BEEF;
        rtData = 32'd3;
        op     = 2'b00;
        start  = 1'b1;
        mthi   = 1'b1;
      end else if (disturb && busyCycles == 6) begin
        start = 1'b0;
        mthi  = 1'b0;
      end
    end
    checkOutput({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    checkOutput({tag, "_busy_cycles"}, busyCycles, 64'd33);
    checkOutput({tag, "_hold"}, {63'd0, holdBad}, 64'd0);
  endtask

  // done must drop after exactly one cycle when nothing new is issued.
  task automatic checkDonePulse(input string tag);
    @(negedge clock);
    checkOutput({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    checkOutput({tag, "_idle_after"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic runOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int cyc;
    applyStimulus(o, a, b, tag, 1'b0, 1'b0, cyc);
    checkDonePulse(tag);
  endtask

  initial begin
    int doneCount;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    reset  = 1'b0;
    start  = 1'b0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    op     = 2'b00;
    rsData = '0;
    rtData = '0;
    mHi    = '0;
    mLo    = '0;

    repeat (2) @(negedge clock);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    runOp(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
    runOp(2'b11, 32'd100, 32'd0, "divu_zero");
    runOp(2'b10, 32'hFFFF_FFF9, 32'd0, "div_zero");
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_minint");
    runOp(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minint");

    // Inputs disturbed mid-operation, then a start in the done cycle.
    applyStimulus(2'b11, 32'd100, 32'd7, "divu_disturb", 1'b1, 1'b0, bc);
    applyStimulus(2'b01, 32'd6, 32'd7, "b2b", 1'b0, 1'b0, bc);
    checkDonePulse("b2b");

    // MTHI alone, then MTHI+MTLO together.
    rsData = 32'h1234_5678;
    mthi   = 1'b1;
    @(posedge clock);
    #1;
    mthi = 1'b0;
    @(negedge clock);
    checkOutput("mthi_hi", {32'd0, hi}, 64'h1234_5678);
    checkOutput("mthi_lo_keep", {32'd0, lo}, {32'd0, mLo});
    mHi = 32'h1234_5678;
    rsData = 32'hCAFE_F00D;
    mthi   = 1'b1;
    mtlo   = 1'b1;
    @(posedge clock);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    @(negedge clock);
    checkOutput("mthilo_hi", {32'd0, hi}, 64'hCAFE_F00D);
    checkOutput("mthilo_lo", {32'd0, lo}, 64'hCAFE_F00D);
    mHi = 32'hCAFE_F00D;
    mLo = 32'hCAFE_F00D;

    // start and mtlo together: mtlo is dropped, lo holds until the result.
    applyStimulus(2'b11, 32'd50, 32'd5, "start_mtlo", 1'b0, 1'b1, bc);
    checkDonePulse("start_mtlo");

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      runOp(ro, ra, rb, $sformatf("rand%0d", i));
    end

    runOp(2'b01, 32'hFFFF_FFFF, 32'd3, "pre_reset");

    // Reset mid-operation: state clears at once and no result appears.
    op     = 2'b00;
    rsData = 32'd5;
    rtData = 32'hFFFF_FFF7;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_done", {63'd0, done}, 64'd0);
    checkOutput("abort_hi", {32'd0, hi}, 64'd0);
    checkOutput("abort_lo", {32'd0, lo}, 64'd0);
    mHi = '0;
    mLo = '0;
    @(negedge clock);
    reset = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("abort_no_done", doneCount, 64'd0);
    checkOutput("abort_idle", {63'd0, busy}, 64'd0);

    runOp(2'b00, 32'd5, 32'hFFFF_FFF7, "after_reset");

    checkOutput("queue_empty", expQ.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
